// File: rtl/lzw_hash_seq.sv
// -----------------------------------------------------------------------------
// lzw_hash_seq
//
// Sequencer for the LZW hash/dictionary datapath. Accepts characters over a
// valid/ready handshake, drives the hash unit's control strobes, interprets
// the lookup results, emits output codes and inserts new dictionary entries.
//
// Optional feature macro: LZW_PROBE_LIMIT_EN
//   defined   - re-probing of one lookup is bounded by PROBE_MAX; when the
//               bound is hit, the current prefix is emitted and no entry is
//               inserted.
//   undefined - no probe counter; re-probing continues until match or
//               not_in_mem.
//
// Handshakes (valid/ready):
//   A transfer happens on the rising clk edge where both valid and ready are
//   high. A producer holds its valid and its data stable until that edge.
//   char_valid/char_ready: the upstream source is the producer. char_ready is
//   a one-cycle strobe, and the character is consumed on the edge that ends
//   that cycle.
//   code_valid/code_ready: this block is the producer. code_out is held until
//   code_ready is seen, and the block stalls for as long as it has to.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   start               begin a stream (only honoured in IDLE)
//   char_valid/last     input character strobe / last-character flag
//   char_ready          one-cycle accept of the current character
//   gen_hash            one-cycle hash request
//   recal_hash          re-probe mode, held for the rest of that lookup
//   shift_char          load string_reg in the hash unit
//   mux_code_val        string_reg source: 0 = character, 1 = code-value RAM
//   not_in_mem, match, collis, in_code_mem   hash unit lookup results
//   string_reg [12:0]   current prefix code from the hash unit
//   dict_we, code_we    dictionary / code-value RAM write strobes
//   new_code [11:0]     code written by code_we
//   code_out [12:0], code_valid, code_ready  emitted code stream
//   busy                high in every state except IDLE
//   done                one-cycle pulse at the end of a stream
//   state_dbg [3:0]     current FSM state (debug visibility)
// -----------------------------------------------------------------------------
module lzw_hash_seq #(
    parameter int FIRST_CODE = 256,
    parameter int CODE_MAX   = 4095,
    parameter int PROBE_MAX  = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        char_valid,
    input  logic        char_last,
    output logic        char_ready,
    output logic        gen_hash,
    output logic        recal_hash,
    output logic        shift_char,
    output logic        mux_code_val,
    input  logic        not_in_mem,
    input  logic        match,
    input  logic        collis,
    input  logic        in_code_mem,
    input  logic [12:0] string_reg,
    output logic        dict_we,
    output logic        code_we,
    output logic [11:0] new_code,
    output logic [12:0] code_out,
    output logic        code_valid,
    input  logic        code_ready,
    output logic        busy,
    output logic        done,
    output logic [3:0]  state_dbg
);

    localparam logic [12:0] FIRST_CODE_L = 13'(FIRST_CODE);
    localparam logic [12:0] CODE_MAX_L   = 13'(CODE_MAX);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_FIRST      = 4'd1,
        S_NEXT       = 4'd2,
        S_W1         = 4'd3,
        S_W2         = 4'd4,
        S_EVAL       = 4'd5,
        S_EXT        = 4'd6,
        S_MISS       = 4'd7,
        S_MISS_NOINS = 4'd8,
        S_INS        = 4'd9,
        S_LOAD       = 4'd10,
        S_FLUSH      = 4'd11,
        S_DONE       = 4'd12
    } state_t;

    state_t      state;
    logic [12:0] next_code;

`ifdef LZW_PROBE_LIMIT_EN
    localparam logic [2:0] PROBE_LIM = 3'(PROBE_MAX);
    logic [2:0] probe_cnt;
`endif

    assign state_dbg = state;

    // All outputs are registered. Each one is set on the transition into the
    // state that owns it, so the strobe is high for exactly the cycle the FSM
    // spends in that state (gen_hash in W1; shift_char/char_ready in LOAD and
    // EXT; dict_we/code_we in INS; done in DONE).
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            next_code    <= FIRST_CODE_L;
            char_ready   <= 1'b0;
            gen_hash     <= 1'b0;
            recal_hash   <= 1'b0;
            shift_char   <= 1'b0;
            mux_code_val <= 1'b0;
            dict_we      <= 1'b0;
            code_we      <= 1'b0;
            new_code     <= '0;
            code_out     <= '0;
            code_valid   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
`ifdef LZW_PROBE_LIMIT_EN
            probe_cnt    <= '0;
`endif
        end else begin
            // Single-cycle strobes fall back to 0 unless a state sets them.
            char_ready   <= 1'b0;
            gen_hash     <= 1'b0;
            shift_char   <= 1'b0;
            mux_code_val <= 1'b0;
            dict_we      <= 1'b0;
            code_we      <= 1'b0;
            done         <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_FIRST;
                        busy      <= 1'b1;
                        next_code <= FIRST_CODE_L;
                    end
                end

                // The first character becomes the prefix without a lookup.
                S_FIRST: begin
                    if (char_valid) begin
                        state      <= S_LOAD;
                        shift_char <= 1'b1;
                        char_ready <= 1'b1;
                    end
                end

                // Look the next character up; it is not consumed yet.
                S_NEXT: begin
                    if (char_valid) begin
                        state    <= S_W1;
                        gen_hash <= 1'b1;
`ifdef LZW_PROBE_LIMIT_EN
                        probe_cnt <= '0;
`endif
                    end
                end

                S_W1: state <= S_W2;

                S_W2: begin
                    if (not_in_mem) begin
                        state      <= S_MISS;
                        code_out   <= string_reg;
                        code_valid <= 1'b1;
                    end else begin
                        state <= S_EVAL;
                    end
                end

                S_EVAL: begin
                    if (match) begin
                        state        <= S_EXT;
                        shift_char   <= 1'b1;
                        mux_code_val <= 1'b1;
                        char_ready   <= 1'b1;
                    end else if (collis || in_code_mem) begin
                        // Slot taken by a different string: probe again.
`ifdef LZW_PROBE_LIMIT_EN
                        if (probe_cnt == PROBE_LIM) begin
                            state      <= S_MISS_NOINS;
                            code_out   <= string_reg;
                            code_valid <= 1'b1;
                        end else begin
                            probe_cnt  <= probe_cnt + 3'd1;
                            state      <= S_W1;
                            gen_hash   <= 1'b1;
                            recal_hash <= 1'b1;
                        end
`else
                        state      <= S_W1;
                        gen_hash   <= 1'b1;
                        recal_hash <= 1'b1;
`endif
                    end else begin
                        // Empty slot not flagged as not_in_mem: treat as miss.
                        state      <= S_MISS;
                        code_out   <= string_reg;
                        code_valid <= 1'b1;
                    end
                end

                S_EXT: begin
                    recal_hash <= 1'b0;
                    state      <= char_last ? S_FLUSH : S_NEXT;
                end

                S_MISS: begin
                    if (code_ready) begin
                        code_valid <= 1'b0;
                        if (next_code <= CODE_MAX_L) begin
                            state    <= S_INS;
                            dict_we  <= 1'b1;
                            code_we  <= 1'b1;
                            new_code <= next_code[11:0];
                        end else begin
                            // Dictionary full: emit only, no write.
                            state      <= S_LOAD;
                            shift_char <= 1'b1;
                            char_ready <= 1'b1;
                        end
                    end
                end

                S_MISS_NOINS: begin
                    if (code_ready) begin
                        code_valid <= 1'b0;
                        state      <= S_LOAD;
                        shift_char <= 1'b1;
                        char_ready <= 1'b1;
                    end
                end

                // next_code only advances here, which is only reachable while
                // next_code <= CODE_MAX, so it saturates at CODE_MAX + 1.
                S_INS: begin
                    next_code  <= next_code + 13'd1;
                    recal_hash <= 1'b0;
                    state      <= S_LOAD;
                    shift_char <= 1'b1;
                    char_ready <= 1'b1;
                end

                S_LOAD: begin
                    recal_hash <= 1'b0;
                    state      <= char_last ? S_FLUSH : S_NEXT;
                end

                // string_reg changes on the edge that leaves LOAD/EXT, so it
                // is captured one cycle into FLUSH rather than on entry.
                S_FLUSH: begin
                    if (!code_valid) begin
                        code_out   <= string_reg;
                        code_valid <= 1'b1;
                    end else if (code_ready) begin
                        code_valid <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_DONE;
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    code_valid <= 1'b0;
                    recal_hash <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lzw_hash_seq.sv
`timescale 1ns/1ps
module tb_lzw_hash_seq;

    localparam int FIRST_CODE = 256;
    localparam int CODE_MAX   = 271;   // small dictionary so streams fill it
    localparam int PROBE_MAX  = 7;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        start = 1'b0;
    logic        char_valid = 1'b0;
    logic        char_last = 1'b0;
    logic [7:0]  char_in = 8'h00;
    logic        char_ready;
    logic        gen_hash, recal_hash, shift_char, mux_code_val;
    logic        not_in_mem = 1'b0;
    logic        match = 1'b0;
    logic        collis = 1'b0;
    logic        in_code_mem = 1'b0;
    logic [12:0] string_reg = '0;
    logic        dict_we, code_we;
    logic [11:0] new_code;
    logic [12:0] code_out;
    logic        code_valid;
    logic        code_ready = 1'b0;
    logic        busy, done;
    logic [3:0]  state_dbg;

    lzw_hash_seq #(
        .FIRST_CODE (FIRST_CODE),
        .CODE_MAX   (CODE_MAX),
        .PROBE_MAX  (PROBE_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .char_valid   (char_valid),
        .char_last    (char_last),
        .char_ready   (char_ready),
        .gen_hash     (gen_hash),
        .recal_hash   (recal_hash),
        .shift_char   (shift_char),
        .mux_code_val (mux_code_val),
        .not_in_mem   (not_in_mem),
        .match        (match),
        .collis       (collis),
        .in_code_mem  (in_code_mem),
        .string_reg   (string_reg),
        .dict_we      (dict_we),
        .code_we      (code_we),
        .new_code     (new_code),
        .code_out     (code_out),
        .code_valid   (code_valid),
        .code_ready   (code_ready),
        .busy         (busy),
        .done         (done),
        .state_dbg    (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    logic [12:0] exp_q[$];      // expected emitted codes
    logic [32:0] ins_q[$];      // expected inserts {prefix, char, code}
    int n_cmp = 0;
    int n_err = 0;

    int cyc = 0;
    int last_xfer_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int overlap_cnt = 0;
    int unstable_cnt = 0;
    int dict_we_cnt = 0;
    int reprobe_cnt = 0;

    // knobs for the hash-unit environment
    bit ready_hold = 1'b0;
    bit force_collis = 1'b0;
    int coll_fixed = -1;        // -1: random collision count per lookup

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp_v);
        end
    endtask

    // ---------------- hash unit / dictionary environment ----------------
    // Dictionary is an associative array keyed by {prefix, char}; collisions
    // are injected as a per-lookup count of "slot taken" results.
    logic [12:0] env_dict [logic [20:0]];
    int coll_left = 0;
    bit coll_pending = 1'b0;
    bit lookup_had_coll = 1'b0;

    always @(negedge clk) begin : hash_env
        logic [20:0] key;
        logic [32:0] exp_i;
        key = {string_reg, char_in};
        if (start && !busy) begin
            env_dict.delete();
            coll_pending = 1'b0;
            lookup_had_coll = 1'b0;
            reprobe_cnt = 0;
        end
        if (gen_hash) begin
            check("recal_on_gen", recal_hash, coll_pending);
            if (!coll_pending) begin
                lookup_had_coll = 1'b0;
                if (force_collis)         coll_left = 1 << 20;
                else if (coll_fixed >= 0) coll_left = coll_fixed;
                else                      coll_left = $urandom_range(0, 2);
            end else begin
                reprobe_cnt++;
            end
            if (coll_left > 0) begin
                coll_left--;
                coll_pending = 1'b1;
                lookup_had_coll = 1'b1;
                not_in_mem = 1'b0;
                match = 1'b0;
                collis = ($urandom_range(0, 1) == 1);
                in_code_mem = 1'b1;
            end else begin
                coll_pending = 1'b0;
                collis = 1'b0;
                if (env_dict.exists(key)) begin
                    match = 1'b1; in_code_mem = 1'b1; not_in_mem = 1'b0;
                end else begin
                    match = 1'b0; in_code_mem = 1'b0; not_in_mem = 1'b1;
                end
            end
        end
        if (dict_we || code_we) begin
            check("we_pair", {dict_we, code_we}, 2'b11);
            check("ins_recal", recal_hash, lookup_had_coll);
            if (ins_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL ins_unexp: write prefix 0x%0h char 0x%0h code 0x%0h, required no write",
                         string_reg, char_in, new_code);
            end else begin
                exp_i = ins_q.pop_front();
                check("ins", {string_reg, char_in, new_code}, exp_i);
            end
            env_dict[key] = {1'b0, new_code};
            dict_we_cnt++;
        end
        if (shift_char) begin
            coll_pending = 1'b0;
            if (mux_code_val)
                string_reg = env_dict.exists(key) ? env_dict[key] : 13'h1fff;
            else
                string_reg = {5'd0, char_in};
        end
    end

    // code_ready: random back-pressure, or held low on request
    always @(posedge clk) begin
        #1;
        code_ready = ready_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // ---------------- monitor ----------------
    logic        prev_stall = 1'b0;
    logic [12:0] prev_code = '0;
    always @(negedge clk) begin : monitor
        cyc++;
        if (prev_stall && code_valid && code_out !== prev_code) unstable_cnt++;
        prev_stall = code_valid && !code_ready && !rst;
        prev_code  = code_out;
        if (code_valid && code_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL code_unexp: got 0x%0h, required no code", code_out);
            end else begin
                check("code", code_out, exp_q.pop_front());
            end
            last_xfer_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (char_ready && gen_hash) overlap_cnt++;
    end

    // ---------------- reference model: plain LZW ----------------
    task automatic ref_lzw(input logic [7:0] s[$]);
        int dict [int];
        int w, nxt, key;
        nxt = FIRST_CODE;
        w = int'(s[0]);
        for (int i = 1; i < s.size(); i++) begin
            key = w * 256 + int'(s[i]);
            if (dict.exists(key)) begin
                w = dict[key];
            end else begin
                exp_q.push_back(13'(w));
                if (nxt <= CODE_MAX) begin
                    dict[key] = nxt;
                    ins_q.push_back({13'(w), s[i], 12'(nxt)});
                    nxt++;
                end
                w = int'(s[i]);
            end
        end
        exp_q.push_back(13'(w));
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_start_busy();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic send_char(input logic [7:0] c, input logic last);
        int t;
        char_in = c; char_last = last; char_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (char_ready) break;
            t++;
            if (t > 3000) begin
                n_cmp++; n_err++;
                $display("FAIL char_accept: no char_ready for char 0x%0h, required accept", c);
                break;
            end
        end
        @(posedge clk); #1 char_valid = 1'b0; char_last = 1'b0;
    endtask

    task automatic run_stream(input logic [7:0] s[$], input bit use_ref, input bit poke_start);
        int t, d0;
        if (use_ref) ref_lzw(s);
        d0 = done_cnt;
        do_start();
        for (int i = 0; i < s.size(); i++) begin
            send_char(s[i], i == s.size() - 1);
            if (i == 0 && s.size() > 1) begin
                check("busy", busy, 1);
                if (poke_start) pulse_start_busy();
            end
        end
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("done_cnt", done_cnt - d0, 1);
        check("done_lat", done_cyc - last_xfer_cyc, 1);
        check("codes_left", exp_q.size(), 0);
        check("ins_left", ins_q.size(), 0);
        exp_q.delete();
        ins_q.delete();
        @(posedge clk); #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] s[$];
        int t, we0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_state", state_dbg, 0);
        check("rst_strobes", {char_ready, gen_hash, recal_hash, shift_char, mux_code_val,
                              dict_we, code_we, code_valid, busy, done}, 10'd0);
        check("rst_code_out", code_out, 0);
        check("rst_new_code", new_code, 0);

        // single character
        s = '{8'h41};
        run_stream(s, 1'b1, 1'b0);
        check("single_no_we", dict_we_cnt, 0);

        // ABAB: 0x41, 0x42, 0x100 with inserts 256 (AB) and 257 (BA)
        s = '{8'h41, 8'h42, 8'h41, 8'h42};
        run_stream(s, 1'b1, 1'b0);
        check("abab_we", dict_we_cnt, 2);

        // two collisions then not_in_mem
        coll_fixed = 2;
        s = '{8'h41, 8'h42};
        run_stream(s, 1'b1, 1'b0);
        check("reprobes_2", reprobe_cnt, 2);
        coll_fixed = -1;

`ifdef LZW_PROBE_LIMIT_EN
        // endless collisions: bounded re-probes, prefix emitted, no insert
        force_collis = 1'b1;
        we0 = dict_we_cnt;
        exp_q.push_back(13'h041);
        exp_q.push_back(13'h042);
        s = '{8'h41, 8'h42};
        run_stream(s, 1'b0, 1'b0);
        check("probe_limit", reprobe_cnt, PROBE_MAX);
        check("probe_no_we", dict_we_cnt - we0, 0);
        force_collis = 1'b0;
`endif

        // long stream fills the dictionary
        s.delete();
        for (int i = 0; i < 120; i++) s.push_back(8'h41 + 8'($urandom_range(0, 2)));
        run_stream(s, 1'b1, 1'b0);

        // random streams, one with start poked while busy
        for (int k = 0; k < 12; k++) begin
            s.delete();
            for (int i = 0; i < $urandom_range(1, 50); i++)
                s.push_back(8'h41 + 8'($urandom_range(0, 3)));
            run_stream(s, 1'b1, k == 3);
        end

        // reset while stalled in MISS
        coll_fixed = 0;
        ready_hold = 1'b1;
        we0 = dict_we_cnt;
        do_start();
        send_char(8'h41, 1'b0);
        char_in = 8'h42; char_last = 1'b1; char_valid = 1'b1;
        t = 0;
        while (!code_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("miss_valid", code_valid, 1);
        repeat (10) @(negedge clk);
        check("miss_hold_valid", code_valid, 1);
        check("miss_hold_code", code_out, 13'h041);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        char_valid = 1'b0; char_last = 1'b0;
        @(negedge clk);
        check("rst_mid_valid", code_valid, 0);
        check("rst_mid_state", state_dbg, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_no_we", dict_we_cnt - we0, 0);
        ready_hold = 1'b0;
        coll_fixed = -1;
        repeat (3) @(negedge clk);

        check("ready_vs_gen", overlap_cnt, 0);
        check("code_stable", unstable_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        n_cmp++; n_err++;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
